// File: rtl/cci_mpf_shim_tx_buffer.sv
// TX edge buffer: per-channel FIFOs that strip the MPF header extension before the physical CCI.
// Optional request/stall counters are built only when CCI_MPF_TX_BUFFER_STATS_EN is defined.

package cci_mpf_shim_tx_buffer_pkg;
    localparam int CCI_MDATA_WIDTH           = 16;
    localparam int CCI_CLADDR_WIDTH          = 42;
    localparam int CCI_CLDATA_WIDTH          = 512;
    localparam int CCI_ALMOST_FULL_THRESHOLD = 8;

    typedef struct packed {
        logic [3:0]                  req_type;
        logic [1:0]                  vc_sel;
        logic [CCI_CLADDR_WIDTH-1:0] address;
        logic [CCI_MDATA_WIDTH-1:0]  mdata;
    } t_cci_c0_ReqMemHdr;

    typedef struct packed {
        logic [3:0]                  req_type;
        logic [1:0]                  vc_sel;
        logic                        sop;
        logic [CCI_CLADDR_WIDTH-1:0] address;
        logic [CCI_MDATA_WIDTH-1:0]  mdata;
    } t_cci_c1_ReqMemHdr;

    typedef struct packed {
        logic addrIsVirtual;
        logic mapVAtoPhysChannel;
        logic checkLoadStoreOrder;
    } t_cci_mpf_ReqMemHdrExt;

    typedef struct packed {
        t_cci_mpf_ReqMemHdrExt ext;
        t_cci_c0_ReqMemHdr     base;
    } t_cci_mpf_c0_ReqMemHdr;

    typedef struct packed {
        t_cci_mpf_ReqMemHdrExt ext;
        t_cci_c1_ReqMemHdr     base;
    } t_cci_mpf_c1_ReqMemHdr;

    typedef struct packed {
        t_cci_mpf_c0_ReqMemHdr hdr;
        logic                  rdValid;
    } t_if_cci_mpf_c0_Tx;

    typedef struct packed {
        t_cci_mpf_c1_ReqMemHdr       hdr;
        logic [CCI_CLDATA_WIDTH-1:0] data;
        logic                        wrValid;
        logic                        intrValid;
    } t_if_cci_mpf_c1_Tx;

    typedef struct packed {
        t_cci_c0_ReqMemHdr hdr;
        logic              rdValid;
    } t_if_cci_c0_Tx;

    typedef struct packed {
        t_cci_c1_ReqMemHdr           hdr;
        logic [CCI_CLDATA_WIDTH-1:0] data;
        logic                        wrValid;
        logic                        intrValid;
    } t_if_cci_c1_Tx;
endpackage

module cci_mpf_shim_tx_fifo #(
    parameter int W            = 8,
    parameter int DEPTH        = 64,
    parameter int AF_THRESHOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         blocked_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic         almfull_o,
    output logic         overflow_o,
    output logic         accept_o,
    output logic         stall_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESHOLD);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  out_data_q;
    logic          out_valid_q, almfull_q, overflow_q;
    logic          pop, full, accept;

    // A pop frees the slot in the same cycle, so push at full is legal when popping.
    always_comb begin
        pop     = (count_q != '0) && !blocked_i;
        full    = (count_q == DEPTH_C);
        accept  = push_i && (!full || pop);
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            almfull_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
            if (pop)    out_data_q <= mem_q[rd_ptr_q];
            if (push_i && !accept) overflow_q <= 1'b1;
            count_q     <= count_d;
            out_valid_q <= pop;
            almfull_q   <= (DEPTH_C - count_d) <= AF_C;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign almfull_o   = almfull_q;
    assign overflow_o  = overflow_q;
    assign accept_o    = accept;
    assign stall_o     = (count_q != '0) && blocked_i;
endmodule

module cci_mpf_shim_tx_buffer
    import cci_mpf_shim_tx_buffer_pkg::*;
#(
    parameter int C0_DEPTH     = 64,
    parameter int C1_DEPTH     = 64,
    parameter int AF_THRESHOLD = CCI_ALMOST_FULL_THRESHOLD
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  t_if_cci_mpf_c0_Tx          c0_tx_in,
    output logic                       c0_almFull_out,
    input  t_if_cci_mpf_c1_Tx          c1_tx_in,
    output logic                       c1_almFull_out,
    output t_if_cci_c0_Tx              c0_tx_out,
    input  logic                       c0_almFull_in,
    output t_if_cci_c1_Tx              c1_tx_out,
    input  logic                       c1_almFull_in,
    output logic                       err_vaddr,
    output logic [CCI_MDATA_WIDTH-1:0] err_vaddr_mdata,
    output logic [1:0]                 err_overflow,
    output logic [31:0]                stat_c0_req,
    output logic [31:0]                stat_c1_req,
    output logic [31:0]                stat_c0_stall,
    output logic [31:0]                stat_c1_stall
);
    logic [1:0]                 rst_sync_q;
    logic                       rst_n;
    logic                       c0_push, c1_push, c0_bad, c1_bad;
    logic                       c0_out_valid, c1_out_valid;
    logic                       c0_accept, c1_accept, c0_stall, c1_stall;
    t_cci_c0_ReqMemHdr          c0_head;
    t_if_cci_c1_Tx              c1_entry, c1_head;
    logic                       err_vaddr_q;
    logic [CCI_MDATA_WIDTH-1:0] err_vaddr_mdata_q;
    logic                       unused_ext;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        c0_bad   = c0_tx_in.rdValid && c0_tx_in.hdr.ext.addrIsVirtual;
        c1_bad   = (c1_tx_in.wrValid || c1_tx_in.intrValid) && c1_tx_in.hdr.ext.addrIsVirtual;
        c0_push  = c0_tx_in.rdValid && !c0_tx_in.hdr.ext.addrIsVirtual;
        c1_push  = (c1_tx_in.wrValid || c1_tx_in.intrValid) && !c1_tx_in.hdr.ext.addrIsVirtual;
        c1_entry = '{hdr: c1_tx_in.hdr.base, data: c1_tx_in.data,
                     wrValid: c1_tx_in.wrValid, intrValid: c1_tx_in.intrValid};
    end
    assign unused_ext = ^{c0_tx_in.hdr.ext, c1_tx_in.hdr.ext};

    cci_mpf_shim_tx_fifo #(.W($bits(t_cci_c0_ReqMemHdr)), .DEPTH(C0_DEPTH), .AF_THRESHOLD(AF_THRESHOLD)) u_c0_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(c0_push), .push_data_i(c0_tx_in.hdr.base),
        .blocked_i(c0_almFull_in), .out_valid_o(c0_out_valid), .out_data_o(c0_head),
        .almfull_o(c0_almFull_out), .overflow_o(err_overflow[0]), .accept_o(c0_accept), .stall_o(c0_stall)
    );

    cci_mpf_shim_tx_fifo #(.W($bits(t_if_cci_c1_Tx)), .DEPTH(C1_DEPTH), .AF_THRESHOLD(AF_THRESHOLD)) u_c1_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(c1_push), .push_data_i(c1_entry),
        .blocked_i(c1_almFull_in), .out_valid_o(c1_out_valid), .out_data_o(c1_head),
        .almfull_o(c1_almFull_out), .overflow_o(err_overflow[1]), .accept_o(c1_accept), .stall_o(c1_stall)
    );

    always_comb begin
        c0_tx_out           = '0;
        c0_tx_out.hdr       = c0_head;
        c0_tx_out.rdValid   = c0_out_valid;
        c1_tx_out           = c1_head;
        c1_tx_out.wrValid   = c1_head.wrValid && c1_out_valid;
        c1_tx_out.intrValid = c1_head.intrValid && c1_out_valid;
    end

    // Only the first offender is captured; C0 takes priority on a same-cycle tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vaddr_q       <= 1'b0;
            err_vaddr_mdata_q <= '0;
        end else if (!err_vaddr_q && (c0_bad || c1_bad)) begin
            err_vaddr_q       <= 1'b1;
            err_vaddr_mdata_q <= c0_bad ? c0_tx_in.hdr.base.mdata : c1_tx_in.hdr.base.mdata;
        end
    end
    assign err_vaddr       = err_vaddr_q;
    assign err_vaddr_mdata = err_vaddr_mdata_q;

`ifdef CCI_MPF_TX_BUFFER_STATS_EN
    logic [31:0] c0_req_q, c1_req_q, c0_stall_q, c1_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_req_q   <= '0;
            c1_req_q   <= '0;
            c0_stall_q <= '0;
            c1_stall_q <= '0;
        end else begin
            if (c0_accept && (c0_req_q != '1))   c0_req_q   <= c0_req_q + 32'd1;
            if (c1_accept && (c1_req_q != '1))   c1_req_q   <= c1_req_q + 32'd1;
            if (c0_stall && (c0_stall_q != '1))  c0_stall_q <= c0_stall_q + 32'd1;
            if (c1_stall && (c1_stall_q != '1))  c1_stall_q <= c1_stall_q + 32'd1;
        end
    end
    assign stat_c0_req   = c0_req_q;
    assign stat_c1_req   = c1_req_q;
    assign stat_c0_stall = c0_stall_q;
    assign stat_c1_stall = c1_stall_q;
`else
    logic unused_stats;
    assign unused_stats  = ^{c0_accept, c1_accept, c0_stall, c1_stall};
    assign stat_c0_req   = '0;
    assign stat_c1_req   = '0;
    assign stat_c0_stall = '0;
    assign stat_c1_stall = '0;
`endif
endmodule

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Directed bench for cci_mpf_shim_tx_buffer: latency, almost-full, full push/pop, vaddr trap, reset, stats.
module tb_cci_mpf_shim_tx_buffer;
    import cci_mpf_shim_tx_buffer_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    t_if_cci_mpf_c0_Tx c0_tx_in;
    t_if_cci_mpf_c1_Tx c1_tx_in;
    t_if_cci_c0_Tx     c0_tx_out;
    t_if_cci_c1_Tx     c1_tx_out;
    logic              c0_almFull_in, c1_almFull_in, c0_almFull_out, c1_almFull_out;
    logic              err_vaddr;
    logic [15:0]       err_vaddr_mdata;
    logic [1:0]        err_overflow;
    logic [31:0]       stat_c0_req, stat_c1_req, stat_c0_stall, stat_c1_stall;

    int                vec_cnt = 0;
    int                miss_cnt = 0;
    int                c0_seen = 0;
    int                c1_seen = 0;
    logic [31:0]       exp_q[$];

    always #5 clk = ~clk;

    cci_mpf_shim_tx_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .c0_tx_in(c0_tx_in), .c0_almFull_out(c0_almFull_out),
        .c1_tx_in(c1_tx_in), .c1_almFull_out(c1_almFull_out),
        .c0_tx_out(c0_tx_out), .c0_almFull_in(c0_almFull_in),
        .c1_tx_out(c1_tx_out), .c1_almFull_in(c1_almFull_in),
        .err_vaddr(err_vaddr), .err_vaddr_mdata(err_vaddr_mdata), .err_overflow(err_overflow),
        .stat_c0_req(stat_c0_req), .stat_c1_req(stat_c1_req),
        .stat_c0_stall(stat_c0_stall), .stat_c1_stall(stat_c1_stall)
    );

    always @(negedge clk) begin
        if (c0_tx_out.rdValid) c0_seen++;
        if (c1_tx_out.wrValid || c1_tx_out.intrValid) c1_seen++;
    end

    function automatic t_if_cci_mpf_c0_Tx mk_c0(input int addr, input int md, input logic virt);
        t_if_cci_mpf_c0_Tx t;
        t = '0;
        t.hdr.base.address       = 42'(addr);
        t.hdr.base.mdata         = 16'(md);
        t.hdr.ext.addrIsVirtual  = virt;
        t.rdValid                = 1'b1;
        return t;
    endfunction

    function automatic t_if_cci_mpf_c1_Tx mk_c1(input int tag, input logic wr, input logic intr, input logic virt);
        t_if_cci_mpf_c1_Tx t;
        t = '0;
        t.hdr.base.address      = 42'(tag);
        t.hdr.base.mdata        = 16'(tag);
        t.hdr.ext.addrIsVirtual = virt;
        t.data                  = {16{32'(tag)}};
        t.wrValid               = wr;
        t.intrValid             = intr;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic push_c1(input int tag);
        c1_tx_in = mk_c1(tag, 1'b1, 1'b0, 1'b0);
        tick();
        c1_tx_in = '0;
    endtask

    task automatic chk_c1_head(input string tag);
        logic [31:0] e;
        chk({tag, "_qsize"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, c1_tx_out.data[63:0], {e, e});
            chk({tag, "_addr"}, 64'(c1_tx_out.hdr.address), 64'(e));
        end
    endtask

    initial begin
        int base0, base1;
        reset_n = 1'b1;
        c0_tx_in = '0;
        c1_tx_in = '0;
        c0_almFull_in = 1'b0;
        c1_almFull_in = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_c0_valid", c0_tx_out.rdValid, 0);
        chk("rst_c1_valid", {c1_tx_out.wrValid, c1_tx_out.intrValid}, 0);
        chk("rst_almfull", {c0_almFull_out, c1_almFull_out}, 0);
        chk("rst_errs", {err_vaddr, err_overflow}, 0);
        chk("rst_stats", {stat_c0_req, stat_c1_stall}, 0);
        reset_n = 1'b1;
        repeat (3) tick();

        // C0 read: latency T+2
        c0_tx_in = mk_c0('h1234, 5, 1'b0);
        tick();
        c0_tx_in = '0;
        chk("lat_t1_valid", c0_tx_out.rdValid, 0);
        tick();
        chk("lat_t2_valid", c0_tx_out.rdValid, 1);
        chk("lat_t2_addr", 64'(c0_tx_out.hdr.address), 'h1234);
        chk("lat_t2_mdata", 64'(c0_tx_out.hdr.mdata), 5);
        tick();
        chk("lat_t3_valid", c0_tx_out.rdValid, 0);

        // C1 interrupt passes data and valids unchanged
        c1_tx_in = mk_c1(77, 1'b0, 1'b1, 1'b0);
        tick();
        c1_tx_in = '0;
        tick();
        chk("intr_valids", {c1_tx_out.wrValid, c1_tx_out.intrValid}, 2'b01);
        chk("intr_data", c1_tx_out.data[63:0], {2{32'd77}});
        tick();

        // Fill C1 while blocked
        c1_almFull_in = 1'b1;
        for (int i = 0; i < 55; i++) begin
            push_c1(i);
            exp_q.push_back(32'(i));
        end
        chk("af_55", c1_almFull_out, 0);
        push_c1(55);
        exp_q.push_back(32'd55);
        chk("af_56", c1_almFull_out, 1);
        for (int i = 56; i < 64; i++) begin
            push_c1(i);
            exp_q.push_back(32'(i));
        end
        chk("full64_ovf", err_overflow, 0);
        chk("full64_af", c1_almFull_out, 1);
        chk("full64_noout", c1_tx_out.wrValid, 0);

        // Full: push and pop every cycle
        c1_almFull_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            c1_tx_in = mk_c1(100 + k, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(32'(100 + k));
            tick();
            chk("pp_valid", c1_tx_out.wrValid, 1);
            chk_c1_head("pp");
            chk("pp_af", c1_almFull_out, 1);
            chk("pp_ovf", err_overflow, 0);
        end
        c1_tx_in = '0;
        c1_almFull_in = 1'b1;
        tick();
        chk("blk_noout", c1_tx_out.wrValid, 0);
        push_c1(200);
        chk("ovf_65", err_overflow, 2'b10);

        // Drain and check order
        c1_almFull_in = 1'b0;
        for (int n = 0; n < 150 && exp_q.size() != 0; n++) begin
            tick();
            if (c1_tx_out.wrValid) chk_c1_head("drain");
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        repeat (3) tick();
        chk("drain_idle", c1_tx_out.wrValid, 0);
        chk("drain_af", c1_almFull_out, 0);

        // Virtual-address trap
        base0 = c0_seen;
        base1 = c1_seen;
        c0_tx_in = mk_c0('h5000, 'h3A, 1'b1);
        tick();
        c0_tx_in = '0;
        repeat (4) tick();
        chk("va_c0_none", 64'(c0_seen - base0), 0);
        chk("va_flag", err_vaddr, 1);
        chk("va_mdata", err_vaddr_mdata, 'h3A);
        c1_tx_in = mk_c1('h3B, 1'b1, 1'b0, 1'b1);
        tick();
        c1_tx_in = '0;
        repeat (3) tick();
        chk("va_keep", err_vaddr_mdata, 'h3A);
        chk("va_c1_none", 64'(c1_seen - base1), 0);

        // Reset with 20 entries buffered per channel
        c0_almFull_in = 1'b1;
        c1_almFull_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            c0_tx_in = mk_c0(i, i, 1'b0);
            c1_tx_in = mk_c1(300 + i, 1'b1, 1'b0, 1'b0);
            tick();
        end
        c0_tx_in = '0;
        c1_tx_in = '0;
        c0_almFull_in = 1'b0;
        c1_almFull_in = 1'b0;
        tick();
        chk("pre_rst_c0", c0_tx_out.rdValid, 1);
        chk("pre_rst_c1", c1_tx_out.wrValid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valids", {c0_tx_out.rdValid, c1_tx_out.wrValid}, 0);
        chk("mid_rst_af", {c0_almFull_out, c1_almFull_out}, 0);
        chk("mid_rst_errs", {err_vaddr, err_overflow}, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        base0 = c0_seen;
        base1 = c1_seen;
        repeat (12) tick();
        chk("post_rst_c0", 64'(c0_seen - base0), 0);
        chk("post_rst_c1", 64'(c1_seen - base1), 0);

        // Same-cycle offenders: C0 wins
        c0_tx_in = mk_c0('h100, 'h11, 1'b1);
        c1_tx_in = mk_c1('h22, 1'b1, 1'b0, 1'b1);
        tick();
        c0_tx_in = '0;
        c1_tx_in = '0;
        tick();
        chk("va_tie_flag", err_vaddr, 1);
        chk("va_tie_mdata", err_vaddr_mdata, 'h11);

        // 100 accepted reads, then 30 stalled non-empty cycles
        base0 = c0_seen;
        for (int i = 0; i < 100; i++) begin
            c0_tx_in = mk_c0(i, i, 1'b0);
            tick();
        end
        c0_tx_in = '0;
        c0_almFull_in = 1'b1;
        repeat (30) tick();
        c0_almFull_in = 1'b0;
        repeat (5) tick();
        chk("st_emitted", 64'(c0_seen - base0), 100);
`ifdef CCI_MPF_TX_BUFFER_STATS_EN
        chk("st_c0_req", stat_c0_req, 100);
        chk("st_c0_stall", stat_c0_stall, 30);
        chk("st_c1", {stat_c1_req, stat_c1_stall}, 0);
`else
        chk("st_off", {stat_c0_req, stat_c0_stall}, 0);
        chk("st_off_c1", {stat_c1_req, stat_c1_stall}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
